// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer: round-robin or fixed-priority arbiter
// feeding a single registered output stage with valid/ready handshake.
module rr_arb_mux #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter bit RR_MODE    = 1'b1,
  parameter int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]            gnt_out,
  input  logic                         ready_in,
  output logic                         valid_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [SEL_W-1:0]             sel_out
);

  localparam int CW = SEL_W + 1;

  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
  logic [SEL_W-1:0]      rr_ptr;
  logic [SEL_W-1:0]      base;
  logic [SEL_W-1:0]      winner;
  logic [SEL_W-1:0]      ptr_next;
  logic [CW-1:0]         cand;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  found;
  logic                  load;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_data[g] = data_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign load = !valid_out || ready_in;
  assign base = RR_MODE ? rr_ptr : '0;

  // Search starting at base; the one-bit-wider candidate lets the wrap work
  // for channel counts that are not a power of two.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = '0;
    win_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, base} + CW'(k);
      if (cand >= CW'(NUM_CH)) begin
        cand = cand - CW'(NUM_CH);
      end
      if (!found && req_in[cand[SEL_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[SEL_W-1:0];
      end
    end
    win_data = ch_data[winner];
  end

  always_comb begin
    gnt_out = '0;
    if (!rst && load && found) begin
      gnt_out[winner] = 1'b1;
    end
  end

  assign ptr_next = (winner == SEL_W'(NUM_CH - 1)) ? '0 : winner + SEL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      sel_out   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (found) begin
        valid_out <= 1'b1;
        data_out  <= win_data;
        sel_out   <= winner;
        if (RR_MODE) begin
          rr_ptr <= ptr_next;
        end
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule
